// File: rtl/demux8_deser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux8_deser_pkg
// Brief    : Shared widths, FSM state type and slot-to-bit mapping.
// Revision : 1.0
// ============================================================================
package demux8_deser_pkg;

  localparam int SLOT_W = 3;
  localparam int WORD_W = 8;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  function automatic logic [SLOT_W-1:0] slot_to_idx(input logic [SLOT_W-1:0] s,
                                                     input logic msb_first);
    return msb_first ? (SLOT_W'(WORD_W - 1) - s) : s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/demux8_deser_if.sv
`default_nettype none
// ============================================================================
// Module   : demux8_deser_if
// Brief    : Serial-in / word-out bundle for the 8-slot deserializer.
// Revision : 1.0
// ============================================================================
interface demux8_deser_if;
  import demux8_deser_pkg::*;

  logic              din;
  logic              din_valid;
  logic              frame_start;
  logic [WORD_W-1:0] dout;
  logic              dout_valid;
  logic              frame_err;
  logic [SLOT_W-1:0] slot;
  logic              busy;

  modport master (
    output din, din_valid, frame_start,
    input  dout, dout_valid, frame_err, slot, busy
  );

  modport slave (
    input  din, din_valid, frame_start,
    output dout, dout_valid, frame_err, slot, busy
  );

endinterface
`default_nettype wire

// File: rtl/demux8_deser_idle_timer.sv
`default_nettype none
// ============================================================================
// Module   : demux8_deser_idle_timer
// Brief    : Idle-cycle counter with clear, run enable and terminal count.
// Revision : 1.0
// ============================================================================
module demux8_deser_idle_timer #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [TO_W-1:0] r_cnt;
  logic            w_tc;

  generate
    if (TIMEOUT > 0) begin : g_tc
      localparam logic [TO_W-1:0] c_TC = TO_W'(TIMEOUT - 1);
      // Terminal count fires on the cycle that would bring the count to TIMEOUT.
      assign w_tc = i_en & ~i_clr & (r_cnt == c_TC);
    end else begin : g_no_tc
      assign w_tc = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || !i_en || w_tc || (TIMEOUT == 0)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + TO_W'(1);
    end
  end

  assign o_tc = w_tc;

endmodule
`default_nettype wire

// File: rtl/demux8_deser.sv
`default_nettype none
// ============================================================================
// Module   : demux8_deser
// Brief    : 1-to-8 serial deserializer; steers valid bits into slots 0..7.
// Revision : 1.0
// ============================================================================
module demux8_deser
  import demux8_deser_pkg::*;
#(
  parameter int MSB_FIRST = 0,
  parameter int TIMEOUT   = 16,
  parameter int TO_W      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  demux8_deser_if.slave io_link
);

  logic [SLOT_W-1:0] r_slot;
  logic [WORD_W-1:0] r_asm;
  logic [WORD_W-1:0] r_dout;
  logic              r_dout_valid;
  logic              r_frame_err;
  state_t            r_state;

  logic              w_tc;
  logic              w_resync;
  logic              w_abort;
  logic [SLOT_W-1:0] w_slot_base;
  logic [SLOT_W-1:0] w_idx;
  logic [WORD_W-1:0] w_asm_base;
  logic [WORD_W-1:0] w_asm_wr;

  demux8_deser_idle_timer #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_idle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (io_link.din_valid | io_link.frame_start),
    .i_en  (r_slot != '0),
    .o_tc  (w_tc)
  );

  // Resync and timeout share one abort path, so coincident causes give one pulse.
  assign w_resync = io_link.frame_start | w_tc;
  assign w_abort  = w_resync & (r_slot != '0);

  always_comb begin
    w_slot_base     = w_resync ? '0 : r_slot;
    w_asm_base      = w_abort ? '0 : r_asm;
    w_idx           = slot_to_idx(w_slot_base, MSB_FIRST != 0);
    w_asm_wr        = w_asm_base;
    w_asm_wr[w_idx] = io_link.din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot       <= '0;
      r_asm        <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_state      <= IDLE;
    end else begin
      r_dout_valid <= 1'b0;
      r_frame_err  <= w_abort;
      if (io_link.din_valid) begin
        r_asm   <= w_asm_wr;
        r_slot  <= w_slot_base + SLOT_W'(1);
        r_state <= (w_slot_base == '1) ? IDLE : COLLECT;
        if (w_slot_base == '1) begin
          r_dout       <= w_asm_wr;
          r_dout_valid <= 1'b1;
        end
      end else begin
        r_asm   <= w_asm_base;
        r_slot  <= w_slot_base;
        r_state <= (w_slot_base != '0) ? COLLECT : IDLE;
      end
    end
  end

  assign io_link.dout       = r_dout;
  assign io_link.dout_valid = r_dout_valid;
  assign io_link.frame_err  = r_frame_err;
  assign io_link.slot       = r_slot;
  assign io_link.busy       = (r_state == COLLECT);

endmodule
`default_nettype wire

// File: tb/tb_demux8_deser.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux8_deser
// Brief    : Directed self-checking bench for demux8_deser (LSB and MSB variants).
// Revision : 1.0
// ============================================================================
module tb_demux8_deser;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errs;

  demux8_deser_if lsb_if ();
  demux8_deser_if msb_if ();

  // LSB-first variant with a short timeout; MSB-first variant with the default.
  demux8_deser #(.MSB_FIRST(0), .TIMEOUT(4), .TO_W(8)) u_dut_lsb (
    .clk     (clk),
    .rst_n   (rst_n),
    .io_link (lsb_if.slave)
  );

  demux8_deser #(.MSB_FIRST(1), .TIMEOUT(16), .TO_W(8)) u_dut_msb (
    .clk     (clk),
    .rst_n   (rst_n),
    .io_link (msb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic d, input logic dv, input logic fs);
    lsb_if.din         = d;
    lsb_if.din_valid   = dv;
    lsb_if.frame_start = fs;
    msb_if.din         = d;
    msb_if.din_valid   = dv;
    msb_if.frame_start = fs;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input string tag);
    for (int i = 0; i < 8; i++) begin
      step(w[i], 1'b1, 1'b0);
      chk({tag, "_dv"}, 32'(lsb_if.dout_valid), 32'(i == 7));
    end
    chk({tag, "_dout"}, 32'(lsb_if.dout), 32'(w));
    chk({tag, "_slot"}, 32'(lsb_if.slot), 32'd0);
  endtask

  initial begin
    logic [7:0] v_pat;
    n_checks = 0;
    n_errs   = 0;
    rst_n    = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("rst_dout", 32'(lsb_if.dout), 32'd0);
    chk("rst_dv",   32'(lsb_if.dout_valid), 32'd0);
    chk("rst_ferr", 32'(lsb_if.frame_err), 32'd0);
    chk("rst_slot", 32'(lsb_if.slot), 32'd0);
    chk("rst_busy", 32'(lsb_if.busy), 32'd0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);

    // Stream 1,0,1,1,0,0,1,0: 0x4D LSB-first, 0xB2 MSB-first.
    v_pat = 8'b0100_1101;
    for (int i = 0; i < 8; i++) begin
      step(v_pat[i], 1'b1, 1'b0);
      chk("w1_slot", 32'(lsb_if.slot), 32'((i + 1) % 8));
      chk("w1_busy", 32'(lsb_if.busy), 32'(i != 7));
      chk("w1_dv",   32'(lsb_if.dout_valid), 32'(i == 7));
    end
    chk("w1_dout_lsb", 32'(lsb_if.dout), 32'h4D);
    chk("w1_dv_msb",   32'(msb_if.dout_valid), 32'd1);
    chk("w1_dout_msb", 32'(msb_if.dout), 32'hB2);
    step(1'b0, 1'b0, 1'b0);
    chk("w1_dv_drop",  32'(lsb_if.dout_valid), 32'd0);
    chk("w1_dout_hold", 32'(lsb_if.dout), 32'h4D);

    // Back-to-back words, no bubbles.
    send_word(8'hA5, "b2b_a5");
    send_word(8'h3C, "b2b_3c");
    step(1'b0, 1'b0, 1'b0);

    // frame_start at slot 0 is harmless.
    step(1'b0, 1'b0, 1'b1);
    chk("fs_idle_ferr", 32'(lsb_if.frame_err), 32'd0);
    chk("fs_idle_slot", 32'(lsb_if.slot), 32'd0);

    // Resync with a coincident valid bit mid-word.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    chk("rs_slot3", 32'(lsb_if.slot), 32'd3);
    step(1'b1, 1'b1, 1'b1);
    chk("rs_ferr", 32'(lsb_if.frame_err), 32'd1);
    chk("rs_slot1", 32'(lsb_if.slot), 32'd1);
    chk("rs_dv", 32'(lsb_if.dout_valid), 32'd0);
    chk("rs_dout_hold", 32'(lsb_if.dout), 32'h3C);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("rs_ferr_drop", 32'(lsb_if.frame_err), 32'd0);
    end
    chk("rs_dv2", 32'(lsb_if.dout_valid), 32'd1);
    chk("rs_dout", 32'(lsb_if.dout), 32'h01);

    // Timeout after four idle cycles mid-word.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
    chk("to_slot5", 32'(lsb_if.slot), 32'd5);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk("to_pre_ferr", 32'(lsb_if.frame_err), 32'd0);
      chk("to_pre_slot", 32'(lsb_if.slot), 32'd5);
    end
    step(1'b0, 1'b0, 1'b0);
    chk("to_ferr", 32'(lsb_if.frame_err), 32'd1);
    chk("to_slot", 32'(lsb_if.slot), 32'd0);
    chk("to_busy", 32'(lsb_if.busy), 32'd0);
    chk("to_dout_hold", 32'(lsb_if.dout), 32'h01);
    step(1'b0, 1'b0, 1'b0);
    chk("to_ferr_once", 32'(lsb_if.frame_err), 32'd0);
    send_word(8'h5A, "to_next");

    // Timeout coinciding with frame_start gives a single pulse.
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("tofs_ferr", 32'(lsb_if.frame_err), 32'd1);
    chk("tofs_slot", 32'(lsb_if.slot), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("tofs_once", 32'(lsb_if.frame_err), 32'd0);

    // Asynchronous reset between edges at slot 6.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
    chk("ar_slot6", 32'(lsb_if.slot), 32'd6);
    lsb_if.din_valid = 1'b0;
    msb_if.din_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_dout", 32'(lsb_if.dout), 32'd0);
    chk("ar_slot", 32'(lsb_if.slot), 32'd0);
    chk("ar_busy", 32'(lsb_if.busy), 32'd0);
    chk("ar_ferr", 32'(lsb_if.frame_err), 32'd0);
    chk("ar_dv",   32'(lsb_if.dout_valid), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk("ar_ferr_after", 32'(lsb_if.frame_err), 32'd0);
    send_word(8'hC3, "ar_word");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
